// File: rtl/ad_acq_ctrl_pkg.sv
// Shared types and constants for the burst-triggered ADC acquisition controller.
package ad_acq_ctrl_pkg;

  localparam int ADC_W  = 10;
  localparam int HOLD_W = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } acq_state_e;

  // Holdoff length wraps at 20 bits by design.
  function automatic logic [HOLD_W-1:0] holdoff_len(input logic [ADC_W-1:0]  period,
                                                    input logic [HOLD_W-1:0] unit);
    return HOLD_W'(period) * unit;
  endfunction

endpackage

// File: rtl/ad_acq_ctrl_trig_sync.sv
// Two-flop synchroniser and rising-edge detector for the asynchronous trigger.
module trig_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic trig_in,
  output logic trig_rise
);

  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic rdy_q, rdy_d, arm_q, arm_d;

  // Arm only after a genuine low has been sampled, so a trigger already high
  // when reset releases is not mistaken for an edge.
  always_comb begin
    s1_d   = trig_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    rdy_d  = 1'b1;
    arm_d  = arm_q | (rdy_q & ~s1_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rdy_q  <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rdy_q  <= rdy_d;
      arm_q  <= arm_d;
    end
  end

  assign trig_rise = arm_q & s2_q & ~prev_q;

endmodule

// File: rtl/ad_acq_ctrl.sv
// Trigger-delay-capture-holdoff sequencer for a 10-bit ADC stream.
// Define AD_ACQ_TESTPATTERN_EN to replace captured samples with a 10-bit ramp.
//   state   | meaning
//   IDLE    | waiting for a trigger edge
//   DELAY   | counting TRIG_DELAY cycles before the first sample
//   CAPTURE | SAMPLE_NUM valid samples to downstream
//   HOLDOFF | pulse_period*HOLDOFF_UNIT cycles of trigger lockout
module ad_acq_ctrl
  import ad_acq_ctrl_pkg::*;
#(
  parameter int SAMPLE_NUM   = 8192,
  parameter int TRIG_DELAY   = 16,
  parameter int HOLDOFF_UNIT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig_in,
  input  logic [ADC_W-1:0] adc_raw,
  input  logic [ADC_W-1:0] pulse_period,
  output logic [ADC_W-1:0] AD_data_in,
  output logic             AD_data_valid,
  output logic             acq_busy,
  output logic             acq_done,
  output logic [7:0]       trig_miss
);

  localparam int CNT_W = $clog2(SAMPLE_NUM) + 1;
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_NUM - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'((TRIG_DELAY > 0) ? TRIG_DELAY - 1 : 0);

  acq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [HOLD_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0] hold_len;
  logic [7:0]        miss_q, miss_d;
  logic [ADC_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              trig_rise;

  trig_sync u_trig_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .trig_in   (trig_in),
    .trig_rise (trig_rise)
  );

  // Timers are down-counters loaded with length-1 and terminate at zero.
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    timer_d   = timer_q;
    miss_d    = miss_q;
    hold_len  = holdoff_len(pulse_period, HOLD_W'(HOLDOFF_UNIT));
    if (trig_rise && (state_q != IDLE) && (miss_q != 8'hFF))
      miss_d = miss_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          if (TRIG_DELAY == 0) begin
            state_d   = CAPTURE;
            smp_cnt_d = SAMPLE_LAST;
          end else begin
            state_d = DELAY;
            timer_d = DELAY_LAST;
          end
        end
      end
      DELAY: begin
        if (timer_q == '0) begin
          state_d   = CAPTURE;
          smp_cnt_d = SAMPLE_LAST;
        end else begin
          timer_d = timer_q - HOLD_W'(1);
        end
      end
      CAPTURE: begin
        if (smp_cnt_q == '0) begin
          state_d = HOLDOFF;
          timer_d = (hold_len == '0) ? '0 : hold_len - HOLD_W'(1);
        end else begin
          smp_cnt_d = smp_cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == CAPTURE);
    done_d  = (state_q == CAPTURE) && (state_d == HOLDOFF);
  end

`ifdef AD_ACQ_TESTPATTERN_EN
  logic [ADC_W-1:0] ramp_q, ramp_d;

  always_comb begin
    ramp_d = valid_d ? ramp_q + ADC_W'(1) : '0;
    data_d = valid_d ? ramp_q : adc_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ramp_q <= '0;
    else          ramp_q <= ramp_d;
  end
`else
  always_comb begin
    data_d = adc_raw;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      timer_q   <= '0;
      miss_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      timer_q   <= timer_d;
      miss_q    <= miss_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign AD_data_in    = data_q;
  assign AD_data_valid = valid_q;
  assign acq_done      = done_q;
  assign acq_busy      = (state_q != IDLE);
  assign trig_miss     = miss_q;

endmodule

// File: tb/tb_ad_acq_ctrl.sv
// Directed bench for ad_acq_ctrl with default parameters (8192 / 16 / 64).
module tb_ad_acq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       trig_in;
  logic [9:0] adc_raw;
  logic [9:0] pulse_period;
  logic [9:0] AD_data_in;
  logic       AD_data_valid;
  logic       acq_busy;
  logic       acq_done;
  logic [7:0] trig_miss;

  int errors = 0;
  int checks = 0;

  int first_busy, first_valid, vcnt, dcnt, bad, done_ok, rst_hit;
  int hold_n, vseen, dseen, bseen;
  logic [9:0] exp_d;

  always #5 clk = ~clk;

  ad_acq_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .trig_in       (trig_in),
    .adc_raw       (adc_raw),
    .pulse_period  (pulse_period),
    .AD_data_in    (AD_data_in),
    .AD_data_valid (AD_data_valid),
    .acq_busy      (acq_busy),
    .acq_done      (acq_done),
    .trig_miss     (trig_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One acquisition: trigger pulse of 5 cycles, then monitor until acq_done
  // (or until rst_at valid samples, where reset is asserted asynchronously).
  task automatic run_acq(input int ntog, input bit pp_zero, input int rst_at);
    int togs = 0;
    logic pv = 1'b0;
    first_busy = 0; first_valid = 0; vcnt = 0; dcnt = 0; bad = 0;
    done_ok = 0; rst_hit = 0;
    @(posedge clk); #1 trig_in = 1'b1;
    for (int n = 1; n <= 12000; n++) begin
      @(posedge clk); #1;
      if (n == 5) trig_in = 1'b0;
      if (ntog > 0 && vcnt >= 10 && togs < 2 * ntog) begin
        trig_in = ~trig_in;
        togs++;
      end
      if (pp_zero && vcnt == 50) pulse_period = 10'd0;
      if (vcnt == 100) adc_raw = 10'h2AA;
      @(negedge clk);
      if (acq_busy && first_busy == 0) first_busy = n;
      if (AD_data_valid) begin
        vcnt++;
        if (first_valid == 0) first_valid = n;
`ifdef AD_ACQ_TESTPATTERN_EN
        exp_d = 10'((vcnt - 1) % 1024);
`else
        exp_d = (vcnt <= 101) ? 10'h155 : 10'h2AA;
`endif
        if (AD_data_in !== exp_d) bad++;
      end
      if (acq_done) begin
        dcnt++;
        done_ok = (!AD_data_valid && pv) ? 1 : 0;
        break;
      end
      pv = AD_data_valid;
      if (rst_at > 0 && vcnt == rst_at) begin
        reset_n = 1'b0;
        #1;
        rst_hit = 1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; trig_in = 1'b0; adc_raw = 10'h155; pulse_period = 10'd25;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(AD_data_valid), 0);
    chk("rst_busy",  32'(acq_busy), 0);
    chk("rst_done",  32'(acq_done), 0);
    chk("rst_miss",  32'(trig_miss), 0);
    chk("rst_data",  32'(AD_data_in), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // Acquisition 1: latency, sample count, data and latency of adc change
    run_acq(0, 1'b0, 0);
    chk("a1_busy_lat",  32'(first_busy), 3);
    chk("a1_valid_lat", 32'(first_valid), 19);
    chk("a1_valid_cnt", 32'(vcnt), 8192);
    chk("a1_data_bad",  32'(bad), 0);
    chk("a1_done_cnt",  32'(dcnt), 1);
    chk("a1_done_pos",  32'(done_ok), 1);

    // Holdoff of 25*64 cycles with a trigger 100 cycles in
    hold_n = 0; vseen = 0; dseen = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (n == 100) trig_in = 1'b1;
      if (n == 103) trig_in = 1'b0;
      @(negedge clk);
      if (AD_data_valid) vseen++;
      if (acq_done) dseen++;
      if (!acq_busy) begin
        hold_n = n;
        break;
      end
    end
    chk("hold_len",   32'(hold_n), 1600);
    chk("hold_valid", 32'(vseen), 0);
    chk("hold_done",  32'(dseen), 0);
    chk("miss_one",   32'(trig_miss), 1);

    // Acquisition 2: 300 triggers during capture, holdoff set to zero
    adc_raw = 10'h155;
    repeat (5) @(posedge clk);
    run_acq(300, 1'b1, 0);
    chk("a2_valid_lat", 32'(first_valid), 19);
    chk("a2_valid_cnt", 32'(vcnt), 8192);
    chk("a2_data_bad",  32'(bad), 0);
    chk("a2_done_cnt",  32'(dcnt), 1);
    chk("miss_sat",     32'(trig_miss), 255);
    hold_n = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); @(negedge clk);
      if (!acq_busy) begin
        hold_n = n;
        break;
      end
    end
    chk("hold_zero", 32'(hold_n), 1);
    chk("miss_hold", 32'(trig_miss), 255);

    // Acquisition 3: reset at sample 4000
    adc_raw = 10'h155;
    repeat (5) @(posedge clk);
    run_acq(0, 1'b0, 4000);
    chk("a3_rst_hit",   32'(rst_hit), 1);
    chk("a3_valid_cnt", 32'(vcnt), 4000);
    chk("a3_data_bad",  32'(bad), 0);
    chk("a3_rst_valid", 32'(AD_data_valid), 0);
    chk("a3_rst_busy",  32'(acq_busy), 0);
    chk("a3_rst_done",  32'(acq_done), 0);
    chk("a3_rst_miss",  32'(trig_miss), 0);
    chk("a3_rst_data",  32'(AD_data_in), 0);

    // trig_in held high through reset release must not start a capture
    trig_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    vseen = 0; bseen = 0; dseen = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (AD_data_valid) vseen++;
      if (acq_busy) bseen++;
      if (acq_done) dseen++;
    end
    chk("hi_rel_valid", 32'(vseen), 0);
    chk("hi_rel_busy",  32'(bseen), 0);
    chk("hi_rel_done",  32'(dseen), 0);

    // A fresh edge after trig_in has gone low is accepted again
    trig_in = 1'b0;
    repeat (5) @(posedge clk);
    @(posedge clk); #1 trig_in = 1'b1;
    first_busy = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (acq_busy) begin
        first_busy = n;
        break;
      end
    end
    chk("rearm_busy_lat", 32'(first_busy), 3);
    chk("rearm_miss",     32'(trig_miss), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad_acq_ctrl.md
AD_ACQ_CTRL -- requirements
Module: ad_acq_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_NUM, default 8192, number of samples captured per trigger.
REQ-002 SHALL have parameter TRIG_DELAY, default 16, clk cycles from detected trigger edge to first captured sample.
REQ-003 SHALL have parameter HOLDOFF_UNIT, default 64, clk cycles per pulse_period count during holdoff.
REQ-004 SHALL have port clk, input, 1, sole clock; the block uses one clock only.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port trig_in, input, 1, asynchronous burst-excitation trigger; rising edge starts an acquisition.
REQ-007 SHALL have port adc_raw, input, 10, ADC sample bus, sampled on every clk rising edge.
REQ-008 SHALL have port pulse_period, input, 10, holdoff length in HOLDOFF_UNIT steps.
REQ-009 SHALL have port AD_data_in, output, 10, registered sample to the downstream signal processing stage.
REQ-010 SHALL have port AD_data_valid, output, 1, high for exactly SAMPLE_NUM consecutive cycles per acquisition.
REQ-011 SHALL have port acq_busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port acq_done, output, 1, single-cycle pulse on the cycle after the last valid sample.
REQ-013 SHALL have port trig_miss, output, 8, saturating count of triggers dropped while busy.

Function
REQ-014 SHALL pass trig_in through a 2-flop synchroniser plus 1 edge-detect flop; a rising edge is detected 3 cycles after it is presented at trig_in.
REQ-015 SHALL implement FSM states IDLE, DELAY, CAPTURE, HOLDOFF.
REQ-016 IDLE -> DELAY on a detected edge; DELAY lasts exactly TRIG_DELAY cycles (TRIG_DELAY=0 goes straight to CAPTURE).
REQ-017 CAPTURE SHALL assert AD_data_valid for exactly SAMPLE_NUM cycles, using a sample counter of width clog2(SAMPLE_NUM)+1, then go to HOLDOFF.
REQ-018 HOLDOFF SHALL last pulse_period*HOLDOFF_UNIT cycles, computed 20-bit unsigned and latched on HOLDOFF entry; pulse_period=0 returns to IDLE on the next cycle.
REQ-019 AD_data_in SHALL be adc_raw registered once, i.e. 1-cycle latency, and SHALL update every cycle regardless of state.
REQ-020 AD_data_valid SHALL be registered and aligned with the AD_data_in it qualifies.
REQ-021 A detected edge in DELAY, CAPTURE or HOLDOFF SHALL be dropped and SHALL increment trig_miss, which saturates at 255.
REQ-022 An edge detected on the same cycle HOLDOFF ends SHALL be dropped and counted; it is not queued.
REQ-023 acq_done SHALL pulse on the HOLDOFF entry cycle.

Reset
REQ-024 Asserting reset_n low SHALL immediately force the FSM to IDLE and clear all of the following: AD_data_valid, acq_busy, acq_done, trig_miss, AD_data_in, counters and synchroniser flops.
REQ-025 Reset during CAPTURE SHALL drop AD_data_valid with no acq_done; after release the block waits for a new edge.
REQ-026 A trig_in that is already high at reset release SHALL NOT be detected as an edge.

Configuration
REQ-027 With macro AD_ACQ_TESTPATTERN_EN defined, the CAPTURE cycles SHALL drive AD_data_in as a 10-bit ramp starting at 0 and incrementing each valid cycle with wrap at 1023, and adc_raw SHALL be ignored.
REQ-028 Without AD_ACQ_TESTPATTERN_EN, AD_data_in SHALL follow REQ-019 and no ramp logic SHALL be synthesised.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, DELAY=1, CAPTURE=2, HOLDOFF=3) and the 10-bit ADC width constant.
REQ-030 The synchroniser and edge detector SHALL be a sub-module named trig_sync.

Verification
REQ-031 With SAMPLE_NUM=8192 and TRIG_DELAY=16, one trig_in pulse of 5 cycles -> valid rises 3+16 cycles after the edge, is high for exactly 8192 cycles, and acq_done pulses once.
REQ-032 With adc_raw=0x155 held, capture -> every valid AD_data_in equals 0x155, with 1-cycle latency after an adc_raw change to 0x2AA.
REQ-033 With pulse_period=25 and a second trigger 100 cycles after acq_done -> no capture occurs, trig_miss=1; a trigger after 1600 holdoff cycles is accepted.
REQ-034 With 300 triggers issued during CAPTURE -> trig_miss=255 (saturated).
REQ-035 reset_n driven low at sample 4000 -> valid low immediately, no acq_done, FSM in IDLE; trig_in held high through release -> no capture.
REQ-036 With AD_ACQ_TESTPATTERN_EN defined -> valid samples read 0,1,2,...,1023,0,..., and the 8192nd sample is 1023.
